// File: rtl/schoolbook_polymul_seq_pkg.sv
// Shared defaults, FSM state type and counter sizing for the
// sequential schoolbook polynomial multiplier.
package polymul_pkg;

    localparam int N_DEF       = 256;
    localparam int COEFF_W_DEF = 13;
    localparam int SEC_W_DEF   = 4;
    localparam int Q_DEF       = 3329;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Beat counter width; N is a power of two >= 4.
    function automatic int cnt_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/schoolbook_polymul_seq_if.sv
// Control, coefficient stream and result bundle of the multiplier.
// master: stream source / consumer side. slave: the engine.
interface schoolbook_polymul_seq_if
    import polymul_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int COEFF_W = COEFF_W_DEF,
    parameter int SEC_W   = SEC_W_DEF
);
    logic                   start;
    logic                   mode_neg;
    logic                   acc_load;
    logic [N*COEFF_W-1:0]   acc_in;
    logic [N*SEC_W-1:0]     secret_in;
    logic                   a_valid;
    logic                   a_ready;
    logic [COEFF_W-1:0]     a_coeff;
    logic                   busy;
    logic                   done;
    logic [N*COEFF_W-1:0]   result;
    logic                   range_err;

    modport master (
        output start, mode_neg, acc_load, acc_in, secret_in,
        output a_valid, a_coeff,
        input  a_ready, busy, done, result, range_err
    );

    modport slave (
        input  start, mode_neg, acc_load, acc_in, secret_in,
        input  a_valid, a_coeff,
        output a_ready, busy, done, result, range_err
    );

endinterface

// File: rtl/schoolbook_polymul_seq_mac_lane.sv
// One modular MAC lane: r_o = (acc_i + a_i * s_i) mod Q, canonical.
// Ports: acc_i (< Q), a_i (any COEFF_W value), s_i (signed), r_o.
module mod_mac_lane
    import polymul_pkg::*;
#(
    parameter int COEFF_W = COEFF_W_DEF,
    parameter int SEC_W   = SEC_W_DEF,
    parameter int Q       = Q_DEF
) (
    input  logic [COEFF_W-1:0]      acc_i,
    input  logic [COEFF_W-1:0]      a_i,
    input  logic signed [SEC_W:0]   s_i,
    output logic [COEFF_W-1:0]      r_o
);
    // Wide enough for acc + a*s with a full-range a and |s| <= 2**SEC_W.
    localparam int SW = COEFF_W + SEC_W + 3;
    localparam logic signed [SW-1:0] QS = SW'(Q);

    logic signed [SW-1:0] acc_x;
    logic signed [SW-1:0] a_x;
    logic signed [SW-1:0] s_x;
    logic signed [SW-1:0] sum;
    logic signed [SW-1:0] rem;
    logic signed [SW-1:0] fix;

    assign acc_x = {{(SW-COEFF_W){1'b0}}, acc_i};
    assign a_x   = {{(SW-COEFF_W){1'b0}}, a_i};
    assign s_x   = {{(SW-SEC_W-1){s_i[SEC_W]}}, s_i};
    assign sum   = acc_x + a_x * s_x;
    // Signed remainder keeps the dividend's sign; fold negatives up once.
    assign rem   = sum % QS;
    assign fix   = (rem < 0) ? rem + QS : rem;
    assign r_o   = COEFF_W'(fix);

endmodule

// File: rtl/schoolbook_polymul_seq.sv
// Sequential schoolbook multiplier: r = acc + a(x)*s(x) mod (x^N +/- 1), mod Q.
// Ports: clk, rst_n (async, active low), bus (slave side of the stream bundle).
module schoolbook_polymul_seq
    import polymul_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int COEFF_W = COEFF_W_DEF,
    parameter int SEC_W   = SEC_W_DEF,
    parameter int Q       = Q_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    schoolbook_polymul_seq_if.slave bus
);
    localparam int CW = cnt_w(N);

    state_t                     state_q, state_d;
    logic [CW-1:0]              cnt_q;
    logic                       mode_q;
    logic                       rerr_q;
    logic                       done_q;
    logic [COEFF_W-1:0]         lane_q   [N];
    logic [COEFF_W-1:0]         lane_mac [N];
    logic signed [SEC_W:0]      sreg_q   [N];
    logic [N*COEFF_W-1:0]       res_flat;
    logic                       beat;
    logic                       last;
    logic                       load;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        beat    = 1'b0;
        last    = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = RUN;
                    load    = 1'b1;
                end
            end
            RUN: begin
                beat = bus.a_valid;
                last = beat && (cnt_q == CW'(N-1));
                if (last) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    for (genvar j = 0; j < N; j++) begin : g_lane
        mod_mac_lane #(
            .COEFF_W(COEFF_W),
            .SEC_W  (SEC_W),
            .Q      (Q)
        ) u_mac (
            .acc_i(lane_q[j]),
            .a_i  (bus.a_coeff),
            .s_i  (sreg_q[j]),
            .r_o  (lane_mac[j])
        );
    end

    always_comb begin
        res_flat = '0;
        for (int j = 0; j < N; j++)
            res_flat[COEFF_W*j +: COEFF_W] = lane_q[j];
    end

    assign bus.result    = res_flat;
    assign bus.a_ready   = (state_q == RUN);
    assign bus.busy      = (state_q == RUN);
    assign bus.done      = done_q;
    assign bus.range_err = rerr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            rerr_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int j = 0; j < N; j++) begin
                lane_q[j] <= '0;
                sreg_q[j] <= '0;
            end
        end else begin
            state_q <= state_d;
            done_q  <= last;
            if (load) begin
                mode_q <= bus.mode_neg;
                cnt_q  <= '0;
                rerr_q <= 1'b0;
                for (int j = 0; j < N; j++) begin
                    lane_q[j] <= bus.acc_load ?
                        bus.acc_in[COEFF_W*j +: COEFF_W] : '0;
                    // One extra bit so that negating the most negative
                    // secret on wrap-around cannot overflow.
                    sreg_q[j] <= {bus.secret_in[SEC_W*j+SEC_W-1],
                                  bus.secret_in[SEC_W*j +: SEC_W]};
                end
            end else if (beat) begin
                cnt_q <= cnt_q + 1'b1;
                if (bus.a_coeff >= COEFF_W'(Q)) rerr_q <= 1'b1;
                for (int j = 0; j < N; j++)
                    lane_q[j] <= lane_mac[j];
                for (int j = 1; j < N; j++)
                    sreg_q[j] <= sreg_q[j-1];
                sreg_q[0] <= mode_q ? -sreg_q[N-1] : sreg_q[N-1];
            end
        end
    end

endmodule

// File: tb/tb_schoolbook_polymul_seq.sv
// Randomised scoreboard bench for schoolbook_polymul_seq against a
// polynomial-product reference model.
module tb_schoolbook_polymul_seq;

    localparam int N  = 256;
    localparam int CW = 13;
    localparam int SW = 4;
    localparam int Q  = 3329;

    typedef struct {
        logic [N*CW-1:0] res;
        logic            rerr;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    schoolbook_polymul_seq_if #(.N(N), .COEFF_W(CW), .SEC_W(SW)) bus ();

    schoolbook_polymul_seq #(
        .N(N), .COEFF_W(CW), .SEC_W(SW), .Q(Q)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    exp_t sb[$];
    exp_t last_exp;
    exp_t mon_e;
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;
    int   a_v   [N];
    int   s_v   [N];
    int   acc_v [N];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // r = acc + sum_i a_i * x^i * s(x), reduced modulo x^N -/+ 1, then mod Q.
    function automatic logic [N*CW-1:0] model(input bit neg, input bit accld);
        longint r [N];
        logic [N*CW-1:0] out;
        longint v;
        int idx;
        longint sg;
        for (int k = 0; k < N; k++) r[k] = accld ? longint'(acc_v[k]) : 0;
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
                idx = i + k;
                sg  = 1;
                if (idx >= N) begin
                    idx -= N;
                    if (neg) sg = -1;
                end
                r[idx] += sg * longint'(a_v[i]) * longint'(s_v[k]);
            end
        end
        out = '0;
        for (int k = 0; k < N; k++) begin
            v = ((r[k] % Q) + Q) % Q;
            out[CW*k +: CW] = CW'(v);
        end
        return out;
    endfunction

    task automatic cmp_vec(input string nm, input logic [N*CW-1:0] act,
                           input logic [N*CW-1:0] exp);
        int bad;
        bad = -1;
        for (int k = N - 1; k >= 0; k--)
            if (act[CW*k +: CW] !== exp[CW*k +: CW]) bad = k;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s: lane %0d got %0d expected %0d", nm, bad,
                     act[CW*bad +: CW], exp[CW*bad +: CW]);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                last_exp = mon_e;
                cmp_vec("result", bus.result, mon_e.res);
                chk("range_err_at_done", longint'(bus.range_err),
                    longint'(mon_e.rerr));
            end
            done_cnt++;
        end
    end

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_a_ready"}, longint'(bus.a_ready), 0);
        chk({nm, "_busy"}, longint'(bus.busy), 0);
        chk({nm, "_done"}, longint'(bus.done), 0);
        chk({nm, "_range_err"}, longint'(bus.range_err), 0);
        cmp_vec({nm, "_result"}, bus.result, '0);
    endtask

    // abort_at < 0 runs to completion; otherwise reset is pulled at that beat.
    task automatic run_poly(input bit neg, input bit accld, input int gap_pct,
                            input bit noise, input int abort_at);
        logic [N*CW-1:0] acc_p;
        logic [N*SW-1:0] sec_p;
        exp_t e;
        int i, cyc, w, c0;
        bit take;
        for (int k = 0; k < N; k++) begin
            acc_p[CW*k +: CW] = CW'(acc_v[k]);
            sec_p[SW*k +: SW] = SW'(s_v[k]);
        end
        e.res  = model(neg, accld);
        e.rerr = 1'b0;
        for (int k = 0; k < N; k++) if (a_v[k] >= Q) e.rerr = 1'b1;
        c0 = done_cnt;
        @(posedge clk); #1;
        bus.start     = 1'b1;
        bus.mode_neg  = neg;
        bus.acc_load  = accld;
        bus.acc_in    = acc_p;
        bus.secret_in = sec_p;
        sb.push_back(e);
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("range_err_cleared", longint'(bus.range_err), 0);
        chk("busy_in_run", longint'(bus.busy), 1);
        i = 0;
        cyc = 0;
        while (i < N && cyc < 20000) begin
            if (abort_at >= 0 && i == abort_at) begin
                bus.a_valid = 1'b0;
                rst_n = 1'b0;
                e = sb.pop_back();
                #1;
                chk_reset_outputs("abort");
                repeat (3) @(posedge clk);
                #1 rst_n = 1'b1;
                return;
            end
            bus.a_valid = ($urandom_range(99) >= gap_pct);
            bus.a_coeff = CW'(a_v[i]);
            bus.start   = noise && ($urandom_range(7) == 0);
            bus.mode_neg = bus.start ? ~neg : neg;
            bus.acc_load = bus.start ? ~accld : accld;
            bus.secret_in = bus.start ? ~sec_p : sec_p;
            if (bus.a_ready !== 1'b1) chk("a_ready_in_run", longint'(bus.a_ready), 1);
            take = bus.a_valid && bus.a_ready;
            @(posedge clk);
            cyc++;
            if (take) i++;
            #1;
        end
        bus.a_valid = 1'b0;
        bus.start   = 1'b0;
        if (i < N) chk("beat_budget", i, N);
        w = 0;
        while (done_cnt == c0 && w < 20) begin
            @(posedge clk);
            w++;
        end
        #1;
        chk("done_latency", w, 1);
        bus.a_valid = 1'b1;
        bus.a_coeff = CW'($urandom_range(Q - 1));
        chk("a_ready_in_done", longint'(bus.a_ready), 0);
        chk("busy_in_done", longint'(bus.busy), 0);
        repeat (2) @(posedge clk);
        #1;
        bus.a_valid = 1'b0;
        cmp_vec("result_hold", bus.result, last_exp.res);
    endtask

    task automatic clear_vecs();
        for (int k = 0; k < N; k++) begin
            a_v[k] = 0;
            s_v[k] = 0;
            acc_v[k] = 0;
        end
    endtask

    task automatic rand_vecs(input bit wide_a);
        for (int k = 0; k < N; k++) begin
            a_v[k]   = wide_a && ($urandom_range(15) == 0) ?
                       int'($urandom_range(8191)) : int'($urandom_range(Q - 1));
            s_v[k]   = int'($urandom_range(15)) - 8;
            acc_v[k] = int'($urandom_range(Q - 1));
        end
    endtask

    initial begin
        rst_n         = 1'b1;
        bus.start     = 1'b0;
        bus.mode_neg  = 1'b0;
        bus.acc_load  = 1'b0;
        bus.acc_in    = '0;
        bus.secret_in = '0;
        bus.a_valid   = 1'b0;
        bus.a_coeff   = '0;
        #3 rst_n = 1'b0;
        #5;
        chk_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        bus.a_valid = 1'b1;
        chk("a_ready_idle", longint'(bus.a_ready), 0);
        bus.a_valid = 1'b0;

        clear_vecs();
        s_v[0] = 1;
        for (int k = 0; k < N; k++) a_v[k] = k;
        run_poly(1'b1, 1'b0, 0, 1'b0, -1);
        chk("identity_lane_200", longint'(bus.result[CW*200 +: CW]), 200);

        clear_vecs();
        s_v[1] = 1;
        a_v[N-1] = 1;
        run_poly(1'b1, 1'b0, 0, 1'b0, -1);
        chk("x_wrap_neg_lane0", longint'(bus.result[0 +: CW]), 3328);
        chk("x_wrap_neg_lane1", longint'(bus.result[CW +: CW]), 0);
        run_poly(1'b0, 1'b0, 0, 1'b0, -1);
        chk("x_wrap_cyc_lane0", longint'(bus.result[0 +: CW]), 1);

        for (int k = 0; k < N; k++) begin
            s_v[k] = -8;
            a_v[k] = 3328;
            acc_v[k] = 5;
        end
        run_poly(1'b1, 1'b1, 0, 1'b0, -1);
        run_poly(1'b0, 1'b1, 0, 1'b0, -1);

        for (int t = 0; t < 4; t++) begin
            rand_vecs(t[0]);
            run_poly(t[1], t[0], 40, 1'b1, -1);
        end

        rand_vecs(1'b0);
        run_poly(1'b1, 1'b1, 20, 1'b0, 100);
        rand_vecs(1'b0);
        run_poly(1'b1, 1'b1, 20, 1'b1, -1);

        clear_vecs();
        s_v[0] = 1;
        a_v[0] = 8191;
        run_poly(1'b1, 1'b0, 0, 1'b0, -1);
        chk("range_err_set", longint'(bus.range_err), 1);
        chk("big_a_lane0", longint'(bus.result[0 +: CW]), 1533);
        a_v[0] = 7;
        run_poly(1'b0, 1'b0, 10, 1'b0, -1);
        chk("range_err_stays_clear", longint'(bus.range_err), 0);

        repeat (5) @(posedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
